// File: rtl/updown_seq_pkg.sv
// Shared types and constants for the up/down counter sequencer.
package updown_seq_pkg;

    localparam int WIDTH_DEF = 4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/updown_counter_core.sv
// Registered WIDTH-bit up/down counter with modulo wrap and async reset to 0.
module updown_counter_core
    import updown_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             updown,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // next count: step by one in the requested direction when enabled
    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = (updown == DIR_UP) ? count_q + ONE : count_q - ONE;
        end
    end

    // count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q = count_q;

endmodule

// File: rtl/updown_seq_ctrl.sv
// Sequencer that walks an up/down counter one step per cycle to a commanded
// target and pulses done on arrival.
// Optional macro SHORTEST_PATH_EN: choose the shorter modular direction
// (ties go up); otherwise direction is a plain target > q compare.
//
// state | meaning
// IDLE  | ready for a command, counter holds
// RUN   | counter stepping toward target_q
// DONE  | one-cycle done pulse, then back to IDLE
module updown_seq_ctrl
    import updown_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             updown,
    output logic             cnt_en,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             updown_q, updown_d;
    logic             dir_accept;
    logic [WIDTH-1:0] q_step;

`ifdef SHORTEST_PATH_EN
    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
    logic [WIDTH-1:0] dist_up;

    // modular distance going up; anything up to half the ring is the short way
    assign dist_up    = cmd_target - q;
    assign dir_accept = (dist_up <= HALF) ? DIR_UP : DIR_DOWN;
`else
    assign dir_accept = (cmd_target > q) ? DIR_UP : DIR_DOWN;
`endif

    // value q will take if the counter steps this cycle
    assign q_step = (updown_q == DIR_UP) ? q + ONE : q - ONE;

    // next-state and output decode
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        updown_d  = updown_q;
        cmd_ready = 1'b0;
        cnt_en    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    target_d = cmd_target;
                    updown_d = dir_accept;
                    state_d  = (cmd_target == q) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    cnt_en = 1'b1;
                    if (q_step == target_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state, target and direction registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            updown_q <= DIR_DOWN;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            updown_q <= updown_d;
        end
    end

    assign updown = updown_q;

    updown_counter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst    (rst),
        .en     (cnt_en),
        .updown (updown_q),
        .q      (q)
    );

endmodule
